vcdl_delay_scanner: RTL and testbench

VCDL_DELAY_SCANNER -- requirements
Module: vcdl_delay_scanner

---
 rtl/vcdl_scan_pkg.sv | 23 ++
 rtl/vcdl_scan_sampler.sv | 48 ++++
 rtl/vcdl_delay_scanner.sv | 162 ++++++++++++++++
 tb/tb_vcdl_delay_scanner.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vcdl_scan_pkg.sv
// vcdl_scan_pkg: shared scanner state encoding, tap constants and tap clamp helper.
// Exports: TAP_W (tap width, 5), MAX_TAP (31), state_t, clamp_tap().
package vcdl_scan_pkg;

    localparam int TAP_W = 5;
    localparam logic [TAP_W-1:0] MAX_TAP = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SAMPLE,
        S_EVAL,
        S_APPLY,
        S_DONE
    } state_t;

    // Saturate a signed tap value into the legal 0..MAX_TAP range.
    function automatic logic [TAP_W-1:0] clamp_tap(input int v);
        return (v < 0) ? '0 : ((v > int'(MAX_TAP)) ? MAX_TAP : TAP_W'(v));
    endfunction

endpackage

// File: rtl/vcdl_scan_sampler.sv
// vcdl_scan_sampler: counts SAMPLES feedback samples per tap and majority-votes a level.
// Ports: sysclk_i/rst_n_i (sync active-low), clr_i (restart for a new tap),
//        en_i (sample this cycle), fb_i (feedback bit), last_o (final sample
//        taken this cycle; level_o valid next cycle), level_o (ones > SAMPLES/2),
//        ones_o (raw ones count, only with VCDL_SCAN_HISTOGRAM_EN).
module vcdl_scan_sampler #(
    parameter int SAMPLES = 64,
    localparam int CW = $clog2(SAMPLES) + 1
) (
    input  logic          sysclk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          fb_i,
    output logic          last_o,
    output logic          level_o
`ifdef VCDL_SCAN_HISTOGRAM_EN
    ,
    output logic [CW-1:0] ones_o
`endif
);

    logic [CW-2:0] cnt_q, cnt_d;
    logic [CW-1:0] ones_q, ones_d;

    // SAMPLES is a power of two, so the sample counter wraps back to 0 by itself.
    always_comb begin
        cnt_d  = clr_i ? '0 : (en_i ? cnt_q + (CW-1)'(1) : cnt_q);
        ones_d = clr_i ? '0 : ones_q + CW'(en_i & fb_i);
    end

    always_ff @(posedge sysclk_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            ones_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ones_q <= ones_d;
        end
    end

    assign last_o  = en_i && (cnt_q == (CW-1)'(SAMPLES - 1));
    assign level_o = ones_q > CW'(SAMPLES / 2);
`ifdef VCDL_SCAN_HISTOGRAM_EN
    assign ones_o = ones_q;
`endif

endmodule

// File: rtl/vcdl_delay_scanner.sv
// vcdl_delay_scanner: sweeps IDELAY taps 0..31, finds the first low-to-high feedback edge, applies it.
// Ports: sysclk_i, rst_n_i (sync active-low), start_i (scan pulse), abort_i (level),
//        vcdl_fb_q_i (feedback), delay_o/load_o (IDELAY tap and load strobe),
//        busy_o, done_o, found_o, edge_tap_o.
// Option VCDL_SCAN_HISTOGRAM_EN adds hist_addr_i/hist_data_o: per-tap ones counts
// of the last scan, read with one cycle of latency.
module vcdl_delay_scanner
    import vcdl_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLES = 64,
    parameter int EDGE_OFFSET = 0,
    localparam int CW = $clog2(SAMPLES) + 1
) (
    input  logic             sysclk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             vcdl_fb_q_i,
`ifdef VCDL_SCAN_HISTOGRAM_EN
    input  logic [TAP_W-1:0] hist_addr_i,
    output logic [CW-1:0]    hist_data_o,
`endif
    output logic [TAP_W-1:0] delay_o,
    output logic             load_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             found_o,
    output logic [TAP_W-1:0] edge_tap_o
);

    state_t           state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d, edge_q, edge_d, delay_q, delay_d;
    logic             prev_q, prev_d, found_q, found_d, load_q, load_d;
    logic [7:0]       settle_q, settle_d;
    logic             settle_last, s_last, s_level;
`ifdef VCDL_SCAN_HISTOGRAM_EN
    logic [CW-1:0]    s_ones;
`endif

    vcdl_scan_sampler #(.SAMPLES(SAMPLES)) u_sampler (
        .sysclk_i (sysclk_i),
        .rst_n_i  (rst_n_i),
        .clr_i    (state_q == S_LOAD),
        .en_i     (state_q == S_SAMPLE),
        .fb_i     (vcdl_fb_q_i),
        .last_o   (s_last),
        .level_o  (s_level)
`ifdef VCDL_SCAN_HISTOGRAM_EN
        ,
        .ones_o   (s_ones)
`endif
    );

    assign settle_last = settle_q == 8'(SETTLE_CYCLES - 1);

    // delay_d is set on the transition into LOAD/APPLY so the tap is valid
    // in the same cycle as the registered load strobe.
    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        edge_d   = edge_q;
        delay_d  = delay_q;
        prev_d   = prev_q;
        found_d  = found_q;
        settle_d = settle_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    tap_d   = '0;
                    prev_d  = 1'b0;
                    found_d = 1'b0;
                    edge_d  = '0;
                    delay_d = '0;
                end
            end
            S_LOAD:   state_d = S_SETTLE;
            S_SETTLE: begin
                settle_d = settle_last ? '0 : settle_q + 8'd1;
                state_d  = settle_last ? S_SAMPLE : S_SETTLE;
            end
            S_SAMPLE: state_d = s_last ? S_EVAL : S_SAMPLE;
            S_EVAL: begin
                if (s_level && !prev_q && tap_q != '0 && !found_q) begin
                    found_d = 1'b1;
                    edge_d  = tap_q;
                end
                if (tap_q != MAX_TAP) begin
                    tap_d   = tap_q + 5'd1;
                    prev_d  = s_level;
                    delay_d = tap_q + 5'd1;
                    state_d = S_LOAD;
                end else begin
                    delay_d = found_d ? clamp_tap(int'(edge_d) + EDGE_OFFSET) : '0;
                    state_d = S_APPLY;
                end
            end
            S_APPLY:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Abort overrides any pending load; the last loaded tap stays on delay_o.
        if (abort_i && state_q != S_IDLE && state_q != S_DONE) begin
            state_d  = S_DONE;
            found_d  = 1'b0;
            settle_d = '0;
            delay_d  = delay_q;
        end
        load_d = (state_d == S_LOAD) || (state_d == S_APPLY);
    end

    always_ff @(posedge sysclk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            tap_q    <= '0;
            edge_q   <= '0;
            delay_q  <= '0;
            prev_q   <= 1'b0;
            found_q  <= 1'b0;
            load_q   <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            edge_q   <= edge_d;
            delay_q  <= delay_d;
            prev_q   <= prev_d;
            found_q  <= found_d;
            load_q   <= load_d;
            settle_q <= settle_d;
        end
    end

`ifdef VCDL_SCAN_HISTOGRAM_EN
    logic [CW-1:0] hist_q [32];
    logic [CW-1:0] hist_data_q;

    always_ff @(posedge sysclk_i) begin
        if (!rst_n_i || (state_q == S_IDLE && start_i)) begin
            for (int i = 0; i < 32; i++) hist_q[i] <= '0;
        end else if (state_q == S_EVAL) begin
            hist_q[tap_q] <= s_ones;
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (!rst_n_i) hist_data_q <= '0;
        else          hist_data_q <= hist_q[hist_addr_i];
    end

    assign hist_data_o = hist_data_q;
`endif

    assign delay_o    = delay_q;
    assign load_o     = load_q;
    assign busy_o     = state_q != S_IDLE;
    assign done_o     = state_q == S_DONE;
    assign found_o    = found_q;
    assign edge_tap_o = edge_q;

endmodule

// File: tb/tb_vcdl_delay_scanner.sv
// tb_vcdl_delay_scanner: directed and randomized scans of three scanners (offsets 0, +5, -5) against a per-tap model.
module tb_vcdl_delay_scanner;

    localparam int S = 16;
    localparam int N = 64;

    logic clk = 1'b0;
    logic rst_n, start, abort, fb;
    logic [4:0] delay0, delayp, delaym, edge0, edgep, edgem;
    logic load0, loadp, loadm, busy0, busyp, busym, done0, donep, donem;
    logic found0, foundp, foundm;
`ifdef VCDL_SCAN_HISTOGRAM_EN
    logic [6:0] hd0, hdp, hdm;
`endif

    int tests = 0;
    int fails = 0;
    int k[32];
    int nload, ndone;
    int loads[$];
    logic [4:0] lastp, lastm;

    always #5 clk = ~clk;

    vcdl_delay_scanner #(.SETTLE_CYCLES(S), .SAMPLES(N), .EDGE_OFFSET(0)) u0 (
        .sysclk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .vcdl_fb_q_i(fb),
`ifdef VCDL_SCAN_HISTOGRAM_EN
        .hist_addr_i(5'd0), .hist_data_o(hd0),
`endif
        .delay_o(delay0), .load_o(load0), .busy_o(busy0), .done_o(done0),
        .found_o(found0), .edge_tap_o(edge0));

    vcdl_delay_scanner #(.SETTLE_CYCLES(S), .SAMPLES(N), .EDGE_OFFSET(5)) up (
        .sysclk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .vcdl_fb_q_i(fb),
`ifdef VCDL_SCAN_HISTOGRAM_EN
        .hist_addr_i(5'd0), .hist_data_o(hdp),
`endif
        .delay_o(delayp), .load_o(loadp), .busy_o(busyp), .done_o(donep),
        .found_o(foundp), .edge_tap_o(edgep));

    vcdl_delay_scanner #(.SETTLE_CYCLES(S), .SAMPLES(N), .EDGE_OFFSET(-5)) um (
        .sysclk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .vcdl_fb_q_i(fb),
`ifdef VCDL_SCAN_HISTOGRAM_EN
        .hist_addr_i(5'd0), .hist_data_o(hdm),
`endif
        .delay_o(delaym), .load_o(loadm), .busy_o(busym), .done_o(donem),
        .found_o(foundm), .edge_tap_o(edgem));

    // VCDL model: after each load, S settle cycles carry junk, then N sample
    // cycles carry exactly k[tap] ones in a scrambled order.
    initial begin
        int cur_tap, cyc, idx;
        cur_tap = 0;
        cyc = 1000;
        fb = 1'b0;
        forever begin
            @(negedge clk);
            if (load0) begin
                cur_tap = int'(delay0);
                cyc = 0;
            end else if (cyc < 1000) begin
                cyc++;
            end
            idx = cyc - S - 1;
            fb = (idx >= 0 && idx < N) ? (((idx * 37) % N) < k[cur_tap]) : 1'($urandom_range(0, 1));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (load0) begin
                nload++;
                loads.push_back(int'(delay0));
            end
            if (loadp) lastp = delayp;
            if (loadm) lastm = delaym;
            if (done0) ndone++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        nload = 0;
        ndone = 0;
        loads.delete();
    endtask

    // A tap is high when a strict majority of its samples are high; the edge is
    // the first high tap (never tap 0) that follows a low tap.
    task automatic model(output bit f, output int e);
        f = 0;
        e = 0;
        for (int t = 1; t < 32; t++)
            if (!f && 2 * k[t] > N && !(2 * k[t-1] > N)) begin
                f = 1;
                e = t;
            end
    endtask

    function automatic int final_tap(bit f, int e, int off);
        int v;
        v = f ? e + off : 0;
        return v < 0 ? 0 : (v > 31 ? 31 : v);
    endfunction

    task automatic run_scan(input string name, input bit mid_start);
        bit f, seen;
        int e, bad;
        model(f, e);
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 4000; c++) begin
            start = (mid_start && c == 700) ? 1'b1 : 1'b0;
            tick();
            if (done0) begin
                seen = 1;
                break;
            end
        end
        start = 1'b0;
        chk({name, "_done_seen"}, 32'(seen), 1);
        chk({name, "_found"}, 32'(found0), 32'(f));
        chk({name, "_edge"}, 32'(edge0), 32'(f ? e : 0));
        chk({name, "_nload"}, 32'(nload), 33);
        bad = 0;
        for (int t = 0; t < 32; t++)
            if (t >= loads.size() || loads[t] != t) bad++;
        chk({name, "_load_seq"}, 32'(bad), 0);
        chk({name, "_final0"}, 32'(delay0), 32'(final_tap(f, e, 0)));
        chk({name, "_finalp"}, 32'(lastp), 32'(final_tap(f, e, 5)));
        chk({name, "_finalm"}, 32'(lastm), 32'(final_tap(f, e, -5)));
        tick();
        chk({name, "_done_pulse"}, 32'({done0, busy0}), 0);
        chk({name, "_ndone"}, 32'(ndone), 1);
    endtask

    task automatic wait_load(input int tap, output bit ok);
        ok = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (load0 && int'(delay0) == tap) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        for (int t = 0; t < 32; t++) k[t] = 0;
        repeat (3) tick();
        chk("rst_outputs", 32'({delay0, load0, busy0, done0, found0, edge0}), 0);
        chk("rst_delays", 32'({delayp, delaym}), 0);
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 32; t++) k[t] = (t < 13) ? 0 : N;
        run_scan("edge13", 1'b1);

        for (int t = 0; t < 32; t++) k[t] = N;
        run_scan("all_high", 1'b0);

        for (int t = 0; t < 32; t++) k[t] = (t < 30) ? 0 : N;
        run_scan("edge30", 1'b0);

        for (int t = 0; t < 32; t++) k[t] = (t < 2) ? 0 : N;
        run_scan("edge2", 1'b0);

        for (int t = 0; t < 32; t++) k[t] = (t < 5) ? 0 : (t == 5 ? N / 2 : (t == 6 ? N / 2 + 1 : N));
        run_scan("tie", 1'b0);

        for (int t = 0; t < 32; t++) k[t] = (t == 9) ? N / 2 : (t == 20 ? N / 2 + 1 : 0);
        run_scan("tie_isolated", 1'b0);

        for (int t = 0; t < 32; t++) k[t] = (t == 0) ? N : 0;
        run_scan("tap0_high", 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int t = 0; t < 32; t++)
                case ($urandom_range(0, 4))
                    0: k[t] = 0;
                    1: k[t] = N;
                    2: k[t] = N / 2;
                    3: k[t] = N / 2 + 1;
                    default: k[t] = int'($urandom_range(0, N));
                endcase
            run_scan($sformatf("rand%0d", r), 1'b0);
        end

        for (int t = 0; t < 32; t++) k[t] = (t < 3) ? 0 : N;
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_load(7, ok);
        chk("abort_reach_tap7", 32'(ok), 1);
        tick();
        chk("abort_found_before", 32'(found0), 1);
        nload = 0;
        abort = 1'b1;
        tick();
        chk("abort_done", 32'(done0), 1);
        chk("abort_found", 32'(found0), 0);
        chk("abort_delay", 32'(delay0), 7);
        abort = 1'b0;
        tick();
        chk("abort_idle", 32'({busy0, done0}), 0);
        repeat (5) tick();
        chk("abort_no_load", 32'(nload), 0);
        chk("abort_ndone", 32'(ndone), 1);

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        chk("start_abort_load", 32'({busy0, load0, delay0}), 32'({1'b1, 1'b1, 5'd0}));
        tick();
        chk("start_abort_done", 32'({done0, load0}), 32'({1'b1, 1'b0}));
        abort = 1'b0;
        tick();
        chk("start_abort_idle", 32'(busy0), 0);

        for (int t = 0; t < 32; t++) k[t] = (t < 2) ? 0 : N;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_load(4, ok);
        chk("rst_reach_tap4", 32'(ok), 1);
        repeat (2) tick();
        clear_mon();
        rst_n = 1'b0;
        tick();
        chk("midrst_outputs", 32'({delay0, load0, busy0, done0, found0, edge0}), 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("midrst_quiet", 32'(nload + ndone), 0);
        for (int t = 0; t < 32; t++) k[t] = (t < 21) ? 0 : N;
        run_scan("after_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
